// File: rtl/cpa_seq_pkg.sv
// Shared types and constants for the multi-precision add/subtract sequencer.
package cpa_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/cpa_word_add.sv
// One-limb carry-propagate adder; kept separate so a faster adder can drop in.
module cpa_word_add #(
    parameter int WORD_LEN = 16
) (
    input  logic [WORD_LEN-1:0] a,
    input  logic [WORD_LEN-1:0] b,
    input  logic                cin,
    output logic [WORD_LEN-1:0] sum,
    output logic                cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WORD_LEN{1'b0}}, cin};

endmodule

// File: rtl/cpa_mp_sequencer.sv
// Wide add/subtract built from one narrow limb adder, one limb per cycle.
//   state | meaning
//   IDLE  | ready for a new operand pair
//   RUN   | adding limb cnt_q, carry chained through carry_q
//   DONE  | result presented, waiting for out_ready
module cpa_mp_sequencer
    import cpa_seq_pkg::*;
#(
    parameter int WORD_LEN  = 16,
    parameter int NUM_WORDS = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_WORDS*WORD_LEN-1:0]   in_a,
    input  logic [NUM_WORDS*WORD_LEN-1:0]   in_b,
    input  logic                            in_sub,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_WORDS*WORD_LEN:0]     out_sum
);

    localparam int W  = NUM_WORDS * WORD_LEN;
    localparam int CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NUM_WORDS - 1);

    state_t                state, state_nxt;
    logic [W-1:0]          a_q, b_q, res_q;
    logic                  res_top_q;
    logic                  carry_q;
    logic [CW-1:0]         cnt_q;
    logic [WORD_LEN-1:0]   limb_sum;
    logic                  limb_cout;
    logic                  last_limb;

    cpa_word_add #(.WORD_LEN(WORD_LEN)) u_word_add (
        .a    (a_q[WORD_LEN-1:0]),
        .b    (b_q[WORD_LEN-1:0]),
        .cin  (carry_q),
        .sum  (limb_sum),
        .cout (limb_cout)
    );

    assign last_limb = (cnt_q == CNT_LAST);
    assign out_sum   = {res_top_q, res_q};

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ~reset;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (last_limb) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            res_top_q <= 1'b0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        // Subtract as A + ~B + 1: the +1 rides in on the first carry.
                        b_q     <= (in_sub == OP_SUB) ? ~in_b : in_b;
                        carry_q <= in_sub;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> WORD_LEN;
                    b_q     <= b_q >> WORD_LEN;
                    res_q   <= (res_q >> WORD_LEN) | (W'(limb_sum) << (W - WORD_LEN));
                    carry_q <= limb_cout;
                    if (last_limb) begin
                        cnt_q     <= '0;
                        res_top_q <= limb_cout;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
